// File: rtl/pincfg_multi.sv
// Multi-channel step/dir output pin stage: per-channel setup/pulse/gap timing,
// polarity, and sticky shutdown masking. PINCFG_MULTI_PENDING_EN adds a one-deep pending-step slot.
module pincfg_multi #(
  parameter int NUM_CHANNELS = 2,
  parameter int OUT_WIDTH    = 8,
  parameter int DUR_WIDTH    = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_CHANNELS-1:0] step_pulse,
  input  logic [NUM_CHANNELS-1:0] dir,
  output logic [OUT_WIDTH-1:0]    pins_out,
  input  logic                    pin_shutdown,
  input  logic                    wb_stb_i,
  input  logic                    wb_cyc_i,
  input  logic                    wb_we_i,
  input  logic [3:0]              wb_adr_i,
  input  logic [31:0]             wb_dat_i,
  output logic [31:0]             wb_dat_o,
  output logic                    wb_ack_o
);

  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_HIGH, S_LOW} state_t;

  localparam logic [DUR_WIDTH-1:0] CNT_ONE = DUR_WIDTH'(1);

  logic [OUT_WIDTH-1:0] r_polarity;
  logic [DUR_WIDTH-1:0] r_dir_setup;
  logic [DUR_WIDTH-1:0] r_low_min;
  logic [DUR_WIDTH-1:0] r_step_dur [NUM_CHANNELS];

  logic r_sync1;
  logic r_sync2;
  logic r_in_shutdown;

  logic                    w_wr;
  logic                    w_clear;
  logic [NUM_CHANNELS-1:0] w_step_active;
  logic [NUM_CHANNELS-1:0] w_dir_q;
  logic [NUM_CHANNELS-1:0] w_overrun;
  logic [OUT_WIDTH-1:0]    w_pin_raw;
  logic                    w_unused;

  assign w_wr     = wb_cyc_i && wb_stb_i && wb_we_i;
  assign w_clear  = w_wr && (wb_adr_i == 4'd1);
  assign wb_ack_o = 1'b1;
  assign w_unused = ^wb_dat_i;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_polarity  <= '0;
      r_dir_setup <= '0;
      r_low_min   <= '0;
      for (int i = 0; i < NUM_CHANNELS; i++) begin
        r_step_dur[i] <= '0;
      end
    end else if (w_wr) begin
      case (wb_adr_i)
        4'd0:    r_polarity  <= wb_dat_i[OUT_WIDTH-1:0];
        4'd2:    r_dir_setup <= wb_dat_i[DUR_WIDTH-1:0];
        4'd3:    r_low_min   <= wb_dat_i[DUR_WIDTH-1:0];
        default: ;
      endcase
      for (int i = 0; i < NUM_CHANNELS; i++) begin
        if (wb_adr_i == 4'(8 + i)) begin
          r_step_dur[i] <= wb_dat_i[DUR_WIDTH-1:0];
        end
      end
    end
  end

  // Clear beats a same-cycle synchronised shutdown; a held input re-sets it next cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_sync1       <= 1'b0;
      r_sync2       <= 1'b0;
      r_in_shutdown <= 1'b0;
    end else begin
      r_sync1 <= pin_shutdown;
      r_sync2 <= r_sync1;
      if (w_clear) begin
        r_in_shutdown <= 1'b0;
      end else if (r_sync2) begin
        r_in_shutdown <= 1'b1;
      end
    end
  end

  always_comb begin
    wb_dat_o = '0;
    case (wb_adr_i)
      4'd0:    wb_dat_o[OUT_WIDTH-1:0]  = r_polarity;
      4'd1:    wb_dat_o[NUM_CHANNELS:0] = {w_overrun, r_in_shutdown};
      4'd2:    wb_dat_o[DUR_WIDTH-1:0]  = r_dir_setup;
      4'd3:    wb_dat_o[DUR_WIDTH-1:0]  = r_low_min;
      default: ;
    endcase
    for (int i = 0; i < NUM_CHANNELS; i++) begin
      if (wb_adr_i == 4'(8 + i)) begin
        wb_dat_o[DUR_WIDTH-1:0] = r_step_dur[i];
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CHANNELS; gi++) begin : g_ch
      state_t               r_state;
      state_t               w_state_next;
      logic [DUR_WIDTH-1:0] r_cnt;
      logic [DUR_WIDTH-1:0] w_cnt_next;
      logic                 r_dir_q;
      logic                 w_dir_next;
      logic                 r_overrun;
      logic                 w_ovr_next;
      logic                 w_req;
      logic                 w_req_used;
      logic                 w_exit;
      logic                 w_acc;
      logic                 w_acc_dir;
`ifdef PINCFG_MULTI_PENDING_EN
      logic                 r_pend_vld;
      logic                 w_pend_vld_next;
      logic                 r_pend_dir;
      logic                 w_pend_dir_next;
`endif

      always_ff @(posedge clk) begin
        if (!rst_n) begin
          r_state   <= S_IDLE;
          r_cnt     <= '0;
          r_dir_q   <= 1'b0;
          r_overrun <= 1'b0;
`ifdef PINCFG_MULTI_PENDING_EN
          r_pend_vld <= 1'b0;
          r_pend_dir <= 1'b0;
`endif
        end else begin
          r_state   <= w_state_next;
          r_cnt     <= w_cnt_next;
          r_dir_q   <= w_dir_next;
          r_overrun <= w_ovr_next;
`ifdef PINCFG_MULTI_PENDING_EN
          r_pend_vld <= w_pend_vld_next;
          r_pend_dir <= w_pend_dir_next;
`endif
        end
      end

      always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_dir_next   = r_dir_q;
        w_ovr_next   = r_overrun;
        w_req        = step_pulse[gi] && !r_in_shutdown;
        w_req_used   = 1'b0;
        w_exit       = 1'b0;
        w_acc        = 1'b0;
        w_acc_dir    = dir[gi];
`ifdef PINCFG_MULTI_PENDING_EN
        w_pend_vld_next = r_pend_vld;
        w_pend_dir_next = r_pend_dir;
`endif
        case (r_state)
          S_IDLE: begin
            if (w_req) begin
              w_acc      = 1'b1;
              w_req_used = 1'b1;
            end
          end
          S_SETUP: begin
            if (r_cnt == CNT_ONE) begin
              if (r_step_dur[gi] != '0) begin
                w_state_next = S_HIGH;
                w_cnt_next   = r_step_dur[gi];
              end else if (r_low_min != '0) begin
                w_state_next = S_LOW;
                w_cnt_next   = r_low_min;
              end else begin
                w_exit = 1'b1;
              end
            end else begin
              w_cnt_next = r_cnt - CNT_ONE;
            end
          end
          S_HIGH: begin
            if (r_cnt == CNT_ONE) begin
              if (r_low_min != '0) begin
                w_state_next = S_LOW;
                w_cnt_next   = r_low_min;
              end else begin
                w_exit = 1'b1;
              end
            end else begin
              w_cnt_next = r_cnt - CNT_ONE;
            end
          end
          S_LOW: begin
            if (r_cnt == CNT_ONE) begin
              w_exit = 1'b1;
            end else begin
              w_cnt_next = r_cnt - CNT_ONE;
            end
          end
          default: w_state_next = S_IDLE;
        endcase

        if (w_exit) begin
          w_state_next = S_IDLE;
`ifdef PINCFG_MULTI_PENDING_EN
          // A buffered step takes the freed channel first; otherwise a step arriving now does.
          if (r_pend_vld) begin
            w_acc           = 1'b1;
            w_acc_dir       = r_pend_dir;
            w_pend_vld_next = 1'b0;
          end else if (w_req) begin
            w_acc      = 1'b1;
            w_req_used = 1'b1;
          end
`endif
        end

        if (w_req && !w_req_used) begin
`ifdef PINCFG_MULTI_PENDING_EN
          if (!w_pend_vld_next) begin
            w_pend_vld_next = 1'b1;
            w_pend_dir_next = dir[gi];
          end else begin
            w_ovr_next = 1'b1;
          end
`else
          w_ovr_next = 1'b1;
`endif
        end

        if (w_acc) begin
          w_dir_next = w_acc_dir;
          if ((w_acc_dir != r_dir_q) && (r_dir_setup != '0)) begin
            w_state_next = S_SETUP;
            w_cnt_next   = r_dir_setup;
          end else if (r_step_dur[gi] != '0) begin
            w_state_next = S_HIGH;
            w_cnt_next   = r_step_dur[gi];
          end else if (r_low_min != '0) begin
            w_state_next = S_LOW;
            w_cnt_next   = r_low_min;
          end else begin
            w_state_next = S_IDLE;
          end
        end

        if (w_clear) begin
          w_ovr_next = 1'b0;
        end
      end

      assign w_step_active[gi] = (r_state == S_HIGH) && !r_in_shutdown;
      assign w_dir_q[gi]       = r_dir_q;
      assign w_overrun[gi]     = r_overrun;
      assign w_pin_raw[2*gi]   = w_step_active[gi];
      assign w_pin_raw[2*gi+1] = w_dir_q[gi];
    end

    for (gi = 2 * NUM_CHANNELS; gi < OUT_WIDTH; gi++) begin : g_spare
      assign w_pin_raw[gi] = 1'b0;
    end
  endgenerate

  assign pins_out = r_polarity ^ w_pin_raw;

endmodule

// File: tb/tb_pincfg_multi.sv
// Directed bench for pincfg_multi: expected values are queued at stimulus time
// and popped when the corresponding DUT output is sampled.
module tb_pincfg_multi;

  logic        clk;
  logic        rst_n;
  logic [1:0]  step_pulse;
  logic [1:0]  dir;
  logic [7:0]  pins_out;
  logic        pin_shutdown;
  logic        wb_stb_i;
  logic        wb_cyc_i;
  logic        wb_we_i;
  logic [3:0]  wb_adr_i;
  logic [31:0] wb_dat_i;
  logic [31:0] wb_dat_o;
  logic        wb_ack_o;

  pincfg_multi #(.NUM_CHANNELS(2), .OUT_WIDTH(8), .DUR_WIDTH(16)) dut (
    .clk(clk), .rst_n(rst_n), .step_pulse(step_pulse), .dir(dir),
    .pins_out(pins_out), .pin_shutdown(pin_shutdown),
    .wb_stb_i(wb_stb_i), .wb_cyc_i(wb_cyc_i), .wb_we_i(wb_we_i),
    .wb_adr_i(wb_adr_i), .wb_dat_i(wb_dat_i), .wb_dat_o(wb_dat_o),
    .wb_ack_o(wb_ack_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [31:0] exp;
  } sb_t;

  sb_t sb_q[$];
  int  total = 0;
  int  bad   = 0;

  task automatic push(input string tag, input logic [31:0] e);
    sb_t s;
    s.tag = tag;
    s.exp = e;
    sb_q.push_back(s);
  endtask

  task automatic pop_check(input logic [31:0] obs);
    sb_t s;
    total++;
    if (sb_q.size() == 0) begin
      bad++;
      $display("FAIL scoreboard_empty observed=%h expected=none", obs);
      return;
    end
    s = sb_q.pop_front();
    assert (obs === s.exp)
      $display("check %-14s observed=%h expected=%h ok", s.tag, obs, s.exp);
    else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", s.tag, obs, s.exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wb_write(input logic [3:0] adr, input logic [31:0] dat);
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b1;
    wb_adr_i = adr;  wb_dat_i = dat;
    tick();
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
  endtask

  task automatic wb_read(input logic [3:0] adr, output logic [31:0] dat);
    wb_adr_i = adr;
    #1;
    dat = wb_dat_o;
  endtask

  function automatic logic [7:0] exp_pins(input logic [7:0] pol, input logic s0, input logic d0,
                                          input logic s1, input logic d1);
    return pol ^ {4'b0000, d1, s1, d0, s0};
  endfunction

  logic [31:0] rd;
  logic [7:0]  pol;
  int          pulses;
  int          active_cycles;
  logic        prev_bit;
  logic        cur_bit;

  initial begin
    rst_n = 1'b0; step_pulse = '0; dir = '0; pin_shutdown = 1'b0;
    wb_stb_i = 1'b0; wb_cyc_i = 1'b0; wb_we_i = 1'b0; wb_adr_i = '0; wb_dat_i = '0;
    pol = 8'hA5;
    repeat (3) tick();
    rst_n = 1'b1;

    // reset state
    push("reset_pins", 32'h0);            pop_check({24'h0, pins_out});
    wb_read(4'd1, rd); push("reset_status", 32'h0); pop_check(rd);

    // polarity write visible next cycle and on readback
    wb_write(4'd0, 32'h0000_00A5);
    push("pol_pins", {24'h0, exp_pins(pol, 0, 0, 0, 0)}); pop_check({24'h0, pins_out});
    wb_read(4'd0, rd); push("pol_read", 32'h0000_00A5);    pop_check(rd);
    wb_read(4'd5, rd); push("unmapped_read", 32'h0);       pop_check(rd);
    wb_read(4'd10, rd); push("no_chan_read", 32'h0);       pop_check(rd);

    // plain step on channel 0: step_dur=3, low_min=2
    wb_write(4'd8, 32'd3);
    wb_write(4'd3, 32'd2);
    wb_read(4'd8, rd); push("step_dur0_read", 32'd3); pop_check(rd);
    step_pulse[0] = 1'b1;
    tick();                                          // t+1
    step_pulse[0] = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      push($sformatf("ch0_t+%0d", k), {24'h0, exp_pins(pol, (k <= 3), 0, 0, 0)});
      pop_check({24'h0, pins_out});
      if (k < 5) tick();
    end
    tick();                                          // t+6: channel idle again
    step_pulse[0] = 1'b1;
    tick();
    step_pulse[0] = 1'b0;
    push("ch0_restep", {24'h0, exp_pins(pol, 1, 0, 0, 0)}); pop_check({24'h0, pins_out});
    wb_read(4'd1, rd); push("no_overrun", 32'h0); pop_check(rd);
    repeat (8) tick();

    // channel 1 with dir change: dir_setup=4, step_dur[1]=2
    wb_write(4'd2, 32'd4);
    wb_write(4'd9, 32'd2);
    dir[1] = 1'b1;
    step_pulse[1] = 1'b1;
    tick();                                          // t+1
    step_pulse[1] = 1'b0;
    for (int k = 1; k <= 7; k++) begin
      push($sformatf("ch1_t+%0d", k), {24'h0, exp_pins(pol, 0, 0, (k == 5 || k == 6), 1)});
      pop_check({24'h0, pins_out});
      if (k < 7) tick();
    end
    repeat (6) tick();

    // shutdown mid-HIGH on channel 0 (step_dur=10)
    wb_write(4'd8, 32'd10);
    step_pulse[0] = 1'b1;
    tick();                                          // t+1
    step_pulse[0] = 1'b0;
    push("sd_pre", {24'h0, exp_pins(pol, 1, 0, 0, 1)}); pop_check({24'h0, pins_out});
    tick();                                          // t+2
    pin_shutdown = 1'b1;
    tick();                                          // t+3
    pin_shutdown = 1'b0;
    tick();
    tick();                                          // t+5
    push("sd_masked", {24'h0, exp_pins(pol, 0, 0, 0, 1)}); pop_check({24'h0, pins_out});
    wb_read(4'd1, rd); push("sd_flag", 32'h1); pop_check(rd);
    wb_write(4'd1, 32'h0);                           // t+6
    push("sd_unmasked", {24'h0, exp_pins(pol, 1, 0, 0, 1)}); pop_check({24'h0, pins_out});
    wb_read(4'd1, rd); push("sd_cleared", 32'h0); pop_check(rd);
    repeat (14) tick();

    // three back-to-back steps on channel 0
    wb_write(4'd8, 32'd3);
    pulses = 0;
    prev_bit = 1'b0;
    for (int k = 0; k < 30; k++) begin
      step_pulse[0] = (k < 3);
      tick();
      cur_bit = pins_out[0] ^ pol[0];
      if (cur_bit && !prev_bit) pulses++;
      prev_bit = cur_bit;
    end
    step_pulse[0] = 1'b0;
`ifdef PINCFG_MULTI_PENDING_EN
    push("burst_pulses", 32'd2);
`else
    push("burst_pulses", 32'd1);
`endif
    pop_check(32'(pulses));
    wb_read(4'd1, rd); push("burst_overrun", 32'h2); pop_check(rd);
    wb_write(4'd1, 32'h0);
    wb_read(4'd1, rd); push("overrun_clear", 32'h0); pop_check(rd);

    // zero durations: no pin activity, channel stays idle
    wb_write(4'd8, 32'd0);
    wb_write(4'd3, 32'd0);
    active_cycles = 0;
    for (int k = 0; k < 6; k++) begin
      step_pulse[0] = (k == 0 || k == 2);
      tick();
      if (pins_out !== exp_pins(pol, 0, 0, 0, 1)) active_cycles++;
    end
    step_pulse[0] = 1'b0;
    push("zero_dur_pins", 32'd0); pop_check(32'(active_cycles));
    wb_read(4'd1, rd); push("zero_dur_idle", 32'h0); pop_check(rd);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pincfg_multi.md
# pincfg_multi

Parametrised multi-channel successor to the single-channel output pin configuration block. It drives NUM_CHANNELS step/dir pin pairs plus static spare pins, and applies per-pin polarity and sticky shutdown masking. Each channel runs a small state machine that adds these timings:

- programmable dir-to-step setup time
- per-channel step pulse width
- minimum low gap between pulses
- one-deep pending-step buffer

It sits between the step generators and the chip output pads, and is configured over the shared Wishbone slave bus.

## Interface
Parameters:
- NUM_CHANNELS, 2, number of step/dir channels (1..8).
- OUT_WIDTH, 8, number of output pins; must be ≥ 2*NUM_CHANNELS.
- DUR_WIDTH, 16, width of all duration registers and counters.

Ports:
- clk  in  1  single clock for all logic.
- rst_n  in  1  synchronous, active-low reset, sampled on posedge clk.
- step_pulse  in  NUM_CHANNELS  one-cycle step request per channel.
- dir  in  NUM_CHANNELS  requested direction per channel.
- pins_out  out  OUT_WIDTH  pin 2i = step of channel i; pin 2i+1 = dir of channel i; remaining pins are static.
- pin_shutdown  in  1  asynchronous shutdown request.
- wb_stb_i, wb_cyc_i, wb_we_i  in  1 each  Wishbone strobe, cycle and write-enable.
- wb_adr_i  in  4  register address.
- wb_dat_i  in  32  write data.
- wb_dat_o  out  32  read data, combinational from wb_adr_i.
- wb_ack_o  out  1  tied to 1.

## Operation
Register map. A write is active when cyc && stb && we. Unused read bits return 0.
- 0: polarity[OUT_WIDTH-1:0], read/write.
- 1: write = clear in_shutdown and all overrun flags. Read = {overrun[NUM_CHANNELS-1:0] at bits [NUM_CHANNELS:1], in_shutdown at bit 0}.
- 2: dir_setup[DUR_WIDTH-1:0], read/write, shared by all channels.
- 3: low_min[DUR_WIDTH-1:0], read/write, shared by all channels.
- 8+i: step_dur[i][DUR_WIDTH-1:0], read/write, channel i.
- Other addresses: writes ignored, reads return 0.

Per-channel state machine (states IDLE, SETUP, HIGH, LOW) with a down-counter cnt:
- **Accepting a step** (from IDLE with step_pulse[i] high, or from a pending step on LOW exit): latch dir_q ← dir (or the pending dir).
  - If the latched dir differs from the previous dir_q and dir_setup ≠ 0: go to SETUP with cnt = dir_setup.
  - Otherwise, if step_dur ≠ 0: go to HIGH with cnt = step_dur.
  - Otherwise, if low_min ≠ 0: go to LOW with cnt = low_min.
  - Otherwise: stay in IDLE.
- **SETUP, HIGH, LOW:** decrement cnt each cycle. When cnt reaches 1, advance to the next non-zero state in the order SETUP → HIGH → LOW → IDLE.
- **Step pin:** active only in HIGH and while not in_shutdown.
- **Dir pin:** dir_q, switched at step acceptance.
- **Outputs:** pins_out[2i] = polarity[2i] ^ step_active; pins_out[2i+1] = polarity[2i+1] ^ dir_q[i]; spare pins = polarity.
- **Shutdown:** pin_shutdown passes through a 2-flop synchroniser and sets sticky in_shutdown. While in_shutdown:
  - step_pulse inputs are dropped (not accepted, not buffered, no overrun).
  - In-flight HIGH pulses are masked at the pin; the state machine keeps running.
  - Dir pins are unaffected.
- **Simultaneous events:** clear_shutdown and a synchronised shutdown in the same cycle → clear wins. The sticky flag re-sets next cycle if the input is still high.
- **Duration register write during a pulse:** affects only the next count load.

## Timing
- **Reset** (rst_n low at a posedge): all registers, counters, dir_q, pending and flags are 0, all states IDLE, pins_out = 0. Reset mid-pulse aborts the pulse on the next cycle.
- **Step with no dir change** at cycle t: step pin active for cycles t+1 .. t+step_dur; LOW follows for low_min cycles; IDLE at t+step_dur+low_min+1.
- **Step with a dir change:** dir pin changes at t+1; step pin is active from t+1+dir_setup for step_dur cycles.
- **Register write:** visible at outputs and in reads one cycle after the write cycle.
- **Reads:** zero-wait; wb_ack_o is constant 1.

## Configuration
- `PINCFG_MULTI_PENDING_EN` defined: a step arriving while a channel is not IDLE is stored with its dir in a one-deep pending slot and accepted on LOW exit (or HIGH exit if low_min = 0). A step arriving while the slot is already full is dropped and sets overrun[i].
- Undefined: no pending slot. Any step arriving while the channel is not IDLE is dropped and sets overrun[i].

## Test plan
- Reset, then write polarity = 0xA5 → pins_out = 0xA5 next cycle; read address 0 returns 0xA5.
- step_dur[0] = 3, low_min = 2, step on channel 0 with dir unchanged at t → pin 0 toggled at t+1..t+3, restored at t+4; channel back in IDLE at t+6.
- dir_setup = 4, step_dur[1] = 2, step on channel 1 with dir changed → pin 3 flips at t+1; pin 2 active at t+5..t+6.
- Pulse pin_shutdown mid-HIGH → step pin returns to polarity within 3 cycles; read address 1 bit0 = 1; a write to address 1 clears it.
- With PENDING_EN defined: three steps one cycle apart on channel 0 → two pulses emitted, overrun[0] = 1. With it undefined: one pulse emitted, overrun[0] = 1.
- step_dur = 0 and low_min = 0, step request → no pin activity, state stays IDLE.
